// File: rtl/fetch_pkg.sv
// Shared definitions for the IF/ID fetch queue: datapath width, the value
// driven on the ID outputs when no entry is valid, and the fetch-entry layout.
package fetch_pkg;

  localparam int FETCH_W = 32;

  // Value presented on the ID outputs when the queue has nothing valid.
  localparam logic [FETCH_W-1:0] NOP_INSTR = 32'h0000_0000;

  // One fetched item as it travels from IF to ID.
  typedef struct packed {
    logic [FETCH_W-1:0] pc_plus4;
    logic [FETCH_W-1:0] instruction;
  } fetch_entry_t;

  // Bundle a PC+4 / instruction pair into a fetch entry.
  function automatic fetch_entry_t make_entry(input logic [FETCH_W-1:0] pc_plus4,
                                              input logic [FETCH_W-1:0] instruction);
    fetch_entry_t e;
    e.pc_plus4    = pc_plus4;
    e.instruction = instruction;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Storage for the fetch queue: DEPTH x W register array with one synchronous
// write port and one asynchronous read port. Reset clears every entry.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_reg [DEPTH];

  // Clear all entries on reset, otherwise write the addressed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Head entry is read combinationally so ID sees it the cycle after the write.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF -> ID decoupling FIFO. Captures {pc_plus4, instruction} fetches, presents
// the oldest one to ID, back-pressures IF via full and empties on flush.
// Optional build macro: IF_ID_QUEUE_BYPASS_EN -- when defined, a fetch that
// arrives at an empty queue while ID can accept is forwarded combinationally
// to the ID outputs in the same cycle and is not stored.
module if_id_fetch_queue
  import fetch_pkg::*;
#(
  parameter int N     = FETCH_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [N-1:0]             if_pc_plus4,
  input  logic [N-1:0]             if_instruction,
  input  logic                     id_stall,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     id_valid,
  output logic [N-1:0]             id_pc_plus4,
  output logic [N-1:0]             id_instruction
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;
  logic [2*N-1:0] head;

  // Status decodes only from registered occupancy, so full has no input path.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // An entry leaves only when it was actually presented (queue non-empty).
  assign pop = ~empty & ~id_stall & ~flush;

`ifdef IF_ID_QUEUE_BYPASS_EN
  logic bypass;

  // Empty queue and a ready ID: hand the fetch straight through, skip storage.
  assign bypass         = empty & if_valid & ~id_stall & ~flush;
  assign push           = if_valid & ~full & ~flush & ~bypass;
  assign id_valid       = ~empty | bypass;
  assign id_pc_plus4    = bypass ? if_pc_plus4    : (empty ? N'(NOP_INSTR) : head[2*N-1:N]);
  assign id_instruction = bypass ? if_instruction : (empty ? N'(NOP_INSTR) : head[N-1:0]);
`else
  // Registered-only ID path: a fetch is visible one cycle after it is written.
  assign push           = if_valid & ~full & ~flush;
  assign id_valid       = ~empty;
  assign id_pc_plus4    = empty ? N'(NOP_INSTR) : head[2*N-1:N];
  assign id_instruction = empty ? N'(NOP_INSTR) : head[N-1:0];
`endif

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (2 * N)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata ({if_pc_plus4, if_instruction}),
    .raddr (rd_ptr_reg),
    .rdata (head)
  );

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage; sits directly downstream of IF.
- Captures each fetched {pc_plus4, instruction} pair into a small synchronous FIFO and presents the oldest entry to ID with a valid flag.
- Back-pressures IF through a full flag and discards all in-flight entries on a taken branch.
- Lets IF keep fetching while ID is frozen by the hazard unit.

Parameters:
- N, 32, datapath width of pc_plus4 and instruction.
- DEPTH, 4, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  taken-branch kill (branch_taken from EX); empties the queue.
- if_valid  input  1  IF presents a new fetch this cycle.
- if_pc_plus4  input  N  PC+4 of the fetched instruction.
- if_instruction  input  N  fetched instruction word.
- id_stall  input  1  ID cannot accept this cycle (hazard freeze).
- full  output  1  queue holds DEPTH entries; top level ORs this into IF freeze.
- empty  output  1  queue holds 0 entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- id_valid  output  1  id_pc_plus4/id_instruction hold a real entry.
- id_pc_plus4  output  N  head entry PC+4.
- id_instruction  output  N  head entry instruction.

Behaviour:
- Reset, sampled on clk edge while rst=1:
  - count=0, read/write pointers=0, all storage cleared to 0.
  - full=0, empty=1, id_valid=0, id_pc_plus4=0, id_instruction=0.
- push = if_valid & ~full & ~flush.
- pop = id_valid & ~id_stall & ~flush.
- Push: writes the entry at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap, DEPTH is a power of two).
- Pop: rd_ptr increments modulo DEPTH.
- count update: next = count + push - pop; simultaneous push and pop leaves count unchanged, including at count=DEPTH-1 and count=1.
- full and empty decode combinationally from registered count (count==DEPTH, count==0); no combinational path from inputs to full.
- Push while full is impossible by construction. An if_valid asserted while full is dropped; IF must be frozen by full so it re-presents the same fetch.
- Pop while empty is impossible because id_valid=0 when empty.
- ID outputs:
  - Driven from the head entry at rd_ptr; id_valid = ~empty.
  - When empty, id_pc_plus4 and id_instruction are forced to 0; ID must qualify with id_valid.
- Latency: an entry pushed at edge t is visible on the ID outputs after edge t (1 cycle) if the queue was empty.
- FIFO order is strictly preserved.
- Flush has priority over push and pop in the same cycle:
  - pointers and count return to 0; storage contents are not cleared.
  - ID outputs are zero/invalid the next cycle.
  - the IF fetch arriving in the flush cycle is discarded.
- Reset mid-operation behaves as flush plus storage clear; rst has priority over flush.

Optional Feature:
- Macro IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When empty=1, if_valid=1, id_stall=0 and flush=0, the IF inputs drive the ID outputs combinationally with id_valid=1 in the same cycle, and the entry is not stored (zero latency).
  - If id_stall=1, the entry is pushed normally.
  - full remains registered-only.
- Not defined: no input-to-output combinational path; minimum latency is 1 cycle.

Decomposition:
- Shared package (fetch_pkg):
  - NOP_INSTR = 32'h0000_0000, used as the invalid-output value.
  - FETCH_W = 32.
  - A packed fetch-entry typedef {pc_plus4, instruction}.
- One sub-module, fetch_queue_mem: DEPTH x 2N register array with one synchronous write port and one asynchronous read port.
- Pointers, count, flush and handshake logic stay in if_id_fetch_queue.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> count=0, empty=1, full=0, id_valid=0, id_instruction=0.
- Fill with id_stall=1:
  - push instructions 0xE3A01001..0xE3A01004 with pc_plus4 4,8,12,16 -> full=1 after 4th edge, count=4.
  - a 5th if_valid is ignored and count stays 4.
- Drain in order: release id_stall with if_valid=0 -> id_instruction 0xE3A01001,02,03,04 on consecutive cycles, then id_valid=0 and empty=1.
- Simultaneous push and pop:
  - at count=2, one cycle of if_valid=1 and id_stall=0 -> count stays 2.
  - then run 10 more push+pop cycles to force pointer wrap -> order intact.
- Flush with concurrent push:
  - at count=3, flush=1 with if_valid=1 -> next cycle count=0, id_valid=0.
  - the flushed-cycle instruction never appears on the ID outputs.
- Reset mid-stream and bypass:
  - rst at count=2 -> all outputs zero next cycle.
  - with IF_ID_QUEUE_BYPASS_EN defined, empty queue, push 0xEA000002 with id_stall=0 -> id_valid=1 same cycle, count stays 0.
